// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive/transmit types, frame constants and baud increment helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic PARITY_ODD = 1'b1;

  // Rounded fractional increment: round(baud * os * 2^w / clk_hz)
  function automatic logic [63:0] baud_inc(input logic [63:0] clk_hz, input logic [63:0] baud,
                                           input logic [63:0] os, input int w);
    return (((baud * os) << w) + (clk_hz >> 1)) / clk_hz;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - fractional accumulator producing a one-clk tick at Baud*Oversampling
module uart_baud_tick import uart_pkg::*; #(
  parameter int ClkFrequency          = 50000000,
  parameter int Baud                  = 19200,
  parameter int Oversampling          = 16,
  parameter int BaudGeneratorAccWidth = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int          W   = BaudGeneratorAccWidth;
  localparam logic [63:0] INC = baud_inc(64'(ClkFrequency), 64'(Baud), 64'(Oversampling), W);

  logic [W:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= {1'b0, acc[W-1:0]} + INC[W:0];
  end

  assign tick = acc[W];

endmodule

// File: rtl/async_receiver.sv
// rtl/async_receiver.sv - oversampled RS-232 receiver, 8 data bits LSB-first plus stop bit
// RX_PARITY_EN selects 8O1 framing with odd-parity check; undefined gives 8N1.
module async_receiver import uart_pkg::*; #(
  parameter int ClkFrequency          = 50000000,
  parameter int Baud                  = 19200,
  parameter int Oversampling          = 16,
  parameter int BaudGeneratorAccWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] RxD_data,
  output logic                 RxD_data_ready,
  output logic                 RxD_parity_error,
  output logic                 RxD_frame_error,
  output logic                 RxD_busy
);

  localparam int            CW   = $clog2(Oversampling);
  localparam logic [CW-1:0] MID  = CW'(Oversampling / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(Oversampling - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic tick;

  uart_baud_tick #(
    .ClkFrequency          (ClkFrequency),
    .Baud                  (Baud),
    .Oversampling          (Oversampling),
    .BaudGeneratorAccWidth (BaudGeneratorAccWidth)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [1:0] sync;
  logic [1:0] hist;
  logic       bit_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      hist  <= 2'b11;
      bit_f <= 1'b1;
    end else begin
      sync <= {sync[0], RxD};
      if (tick) begin
        hist  <= {hist[0], sync[1]};
        bit_f <= (hist[1] & hist[0]) | (hist[1] & sync[1]) | (hist[0] & sync[1]);
      end
    end
  end

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_err, par_err_n;
  logic                 strobe, ferr_n;
  logic                 sample;

  // Oversampling is a power of two, so cnt wraps from LAST to 0 on its own.
  assign sample = tick && (cnt == LAST);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
    par_err_n = par_err;
    strobe    = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (tick && !bit_f) begin
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          if (cnt == MID) begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = bit_f ? IDLE : DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) cnt_n = cnt + 1'b1;
        if (sample) begin
          shift_n = {bit_f, shift[DATA_BITS-1:1]};
          idx_n   = idx + 1'b1;
          if (idx == LAST_BIT) begin
`ifdef RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef RX_PARITY_EN
        if (tick) cnt_n = cnt + 1'b1;
        if (sample) begin
          par_err_n = (^{shift, bit_f}) != PARITY_ODD;
          state_n   = STOP;
        end
`else
        state_n = IDLE;
`endif
      end
      STOP: begin
        if (tick) cnt_n = cnt + 1'b1;
        if (sample) begin
          strobe  = 1'b1;
          ferr_n  = !bit_f;
          state_n = bit_f ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (tick && bit_f) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      idx              <= '0;
      shift            <= '0;
      par_err          <= 1'b0;
      RxD_data         <= '0;
      RxD_data_ready   <= 1'b0;
      RxD_parity_error <= 1'b0;
      RxD_frame_error  <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      idx            <= idx_n;
      shift          <= shift_n;
      par_err        <= par_err_n;
      RxD_data_ready <= strobe;
      if (strobe) begin
        RxD_data        <= shift;
        RxD_frame_error <= ferr_n;
`ifdef RX_PARITY_EN
        RxD_parity_error <= par_err;
`else
        RxD_parity_error <= 1'b0;
`endif
      end
    end
  end

  assign RxD_busy = (state != IDLE);

endmodule
